// File: rtl/motor_mix_pipe.sv
// Quad-motor mixer: two-stage pipeline (raw sums, then clamped/gated outputs)
// with a valid/ready handshake and an arm-request FSM that forces the motors
// to OUT_MIN until armed.
// Optional feature: define MOTOR_MIX_SLEW_EN to compile a per-motor slew limiter
// on the stage-2 load path. The default build loads the clamped value directly.

module motor_mix_pipe #(
  parameter int unsigned W          = 8,
  parameter int          BASE       = 50,
  parameter int          OUT_MIN    = 0,
  parameter int          OUT_MAX    = 2**W - 1,
  parameter logic [11:0] SIGN_MASK  = 12'h000,
  parameter int unsigned ARM_CYCLES = 4,
  parameter int unsigned SLEW_STEP  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] throttle_offset,
  input  logic [W-1:0] pitch_offset,
  input  logic [W-1:0] roll_offset,
  input  logic [W-1:0] yaw_offset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         arm,
  output logic [W-1:0] motor0,
  output logic [W-1:0] motor1,
  output logic [W-1:0] motor2,
  output logic [W-1:0] motor3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   sat_flag,
  output logic [1:0]   arm_state
);

  // Three guard bits cover the sum of a base and four W-bit terms.
  localparam int unsigned SW = W + 3;
  localparam int unsigned CntW = (ARM_CYCLES < 2) ? 1 : $clog2(ARM_CYCLES);

  localparam logic signed [SW-1:0] BaseS   = SW'(BASE);
  localparam logic signed [SW-1:0] OutMinS = SW'(OUT_MIN);
  localparam logic signed [SW-1:0] OutMaxS = SW'(OUT_MAX);
  localparam logic [W-1:0]         OutMinW = W'(OUT_MIN);
  localparam logic [W-1:0]         OutMaxW = W'(OUT_MAX);

  // A zero step would freeze the limited outputs forever.
  if (SLEW_STEP == 0) begin : g_bad_slew_step
    $error("SLEW_STEP must be nonzero");
  end

  typedef enum logic [1:0] {
    StDisarmed = 2'd0,
    StArming   = 2'd1,
    StArmed    = 2'd2
  } arm_state_e;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic w_advance;

  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  // ---------------------------------------------------------------------------
  // Arm FSM
  // ---------------------------------------------------------------------------
  arm_state_e      r_arm_state, w_arm_state_d;
  logic [CntW-1:0] r_arm_cnt, w_arm_cnt_d;

  // Next-state: count consecutive arm-high cycles, drop to DISARMED on arm low.
  always_comb begin
    w_arm_state_d = r_arm_state;
    w_arm_cnt_d   = r_arm_cnt;
    if (!arm) begin
      w_arm_state_d = StDisarmed;
      w_arm_cnt_d   = '0;
    end else begin
      case (r_arm_state)
        StDisarmed: begin
          // The entry cycle is the first counted arm-high cycle.
          if (ARM_CYCLES <= 1) begin
            w_arm_state_d = StArmed;
            w_arm_cnt_d   = '0;
          end else begin
            w_arm_state_d = StArming;
            w_arm_cnt_d   = CntW'(1);
          end
        end
        StArming: begin
          if (32'(r_arm_cnt) + 32'd1 >= ARM_CYCLES) begin
            w_arm_state_d = StArmed;
            w_arm_cnt_d   = '0;
          end else begin
            w_arm_cnt_d = r_arm_cnt + CntW'(1);
          end
        end
        StArmed: begin
          w_arm_state_d = StArmed;
        end
        default: begin
          w_arm_state_d = StDisarmed;
          w_arm_cnt_d   = '0;
        end
      endcase
    end
  end

  // Arm state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arm_state <= StDisarmed;
      r_arm_cnt   <= '0;
    end else begin
      r_arm_state <= w_arm_state_d;
      r_arm_cnt   <= w_arm_cnt_d;
    end
  end

  assign arm_state = r_arm_state;

  // ---------------------------------------------------------------------------
  // Stage 1: signed mixing sums
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] w_thr;
  logic signed [SW-1:0] w_axis [3];
  logic signed [SW-1:0] w_raw  [4];

  assign w_thr     = {{3{throttle_offset[W-1]}}, throttle_offset};
  assign w_axis[0] = {{3{pitch_offset[W-1]}}, pitch_offset};
  assign w_axis[1] = {{3{roll_offset[W-1]}}, roll_offset};
  assign w_axis[2] = {{3{yaw_offset[W-1]}}, yaw_offset};

  // Per-motor sum; SIGN_MASK bit 3*m+k selects subtraction of axis k.
  always_comb begin
    for (int m = 0; m < 4; m++) begin
      w_raw[m] = BaseS + w_thr;
      for (int k = 0; k < 3; k++) begin
        if (SIGN_MASK[3*m+k]) begin
          w_raw[m] = w_raw[m] - w_axis[k];
        end else begin
          w_raw[m] = w_raw[m] + w_axis[k];
        end
      end
    end
  end

  logic signed [SW-1:0] r_raw [4];
  logic                 r_s1_valid;

  // Stage-1 register: valid tracks in_valid so bubbles propagate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      for (int m = 0; m < 4; m++) begin
        r_raw[m] <= '0;
      end
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        for (int m = 0; m < 4; m++) begin
          r_raw[m] <= w_raw[m];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: clamp, optional slew limit, arm gating
  // ---------------------------------------------------------------------------
  logic [W-1:0] w_clamp [4];
  logic [3:0]   w_sat;
  logic [W-1:0] w_next  [4];
  logic [W-1:0] r_motor [4];
  logic [3:0]   r_sat;
  logic         r_out_valid;
  logic         w_force;

  // Clamp each raw sum into [OUT_MIN, OUT_MAX] and flag saturation.
  always_comb begin
    for (int m = 0; m < 4; m++) begin
      w_sat[m] = 1'b0;
      if (r_raw[m] > OutMaxS) begin
        w_clamp[m] = OutMaxW;
        w_sat[m]   = 1'b1;
      end else if (r_raw[m] < OutMinS) begin
        w_clamp[m] = OutMinW;
        w_sat[m]   = 1'b1;
      end else begin
        w_clamp[m] = r_raw[m][W-1:0];
      end
    end
  end

`ifdef MOTOR_MIX_SLEW_EN
  localparam logic signed [SW-1:0] SlewStepS = SW'(SLEW_STEP);

  logic signed [SW-1:0] w_cur [4];
  logic signed [SW-1:0] w_tgt [4];
  logic signed [SW-1:0] w_up  [4];
  logic signed [SW-1:0] w_dn  [4];

  // Limit the move from the last loaded value to +/-SLEW_STEP.
  always_comb begin
    for (int m = 0; m < 4; m++) begin
      w_cur[m] = {3'b000, r_motor[m]};
      w_tgt[m] = {3'b000, w_clamp[m]};
      w_up[m]  = w_cur[m] + SlewStepS;
      w_dn[m]  = w_cur[m] - SlewStepS;
      if (w_tgt[m] > w_up[m]) begin
        w_next[m] = w_up[m][W-1:0];
      end else if (w_tgt[m] < w_dn[m]) begin
        w_next[m] = w_dn[m][W-1:0];
      end else begin
        w_next[m] = w_clamp[m];
      end
    end
  end
`else
  // No limiter: load the clamped value as is.
  always_comb begin
    for (int m = 0; m < 4; m++) begin
      w_next[m] = w_clamp[m];
    end
  end
`endif

  // The live arm input is included so a disarm wins over a same-cycle load.
  assign w_force = (r_arm_state != StArmed) || !arm;

  // Stage-2 register: holds while stalled; forced loads bypass the limiter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sat       <= 4'b0000;
      for (int m = 0; m < 4; m++) begin
        r_motor[m] <= OutMinW;
      end
    end else if (w_advance) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        if (w_force) begin
          r_sat <= 4'b0000;
          for (int m = 0; m < 4; m++) begin
            r_motor[m] <= OutMinW;
          end
        end else begin
          r_sat <= w_sat;
          for (int m = 0; m < 4; m++) begin
            r_motor[m] <= w_next[m];
          end
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sat_flag  = r_sat;
  assign motor0    = r_motor[0];
  assign motor1    = r_motor[1];
  assign motor2    = r_motor[2];
  assign motor3    = r_motor[3];

endmodule

// File: tb/tb_motor_mix_pipe.sv
// Scoreboard bench for motor_mix_pipe: a default-parameter DUT plus a second
// instance with a mixed SIGN_MASK, both driven by the same stimulus.
module tb_motor_mix_pipe;

  logic       clk;
  logic       rst_n;
  logic [7:0] throttle_offset, pitch_offset, roll_offset, yaw_offset;
  logic       in_valid, out_ready, arm;
  logic       in_ready, out_valid;
  logic [7:0] motor0, motor1, motor2, motor3;
  logic [3:0] sat_flag;
  logic [1:0] arm_state;
  logic       x_in_ready, x_out_valid;
  logic [7:0] xm0, xm1, xm2, xm3;
  logic [3:0] x_sat;
  logic [1:0] x_arm_state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic            forced;
    logic [7:0]      a;
    logic [3:0]      asat;
    logic [3:0][7:0] x;
    logic [3:0]      xsat;
  } exp_t;

  exp_t       q[$];
  logic [31:0] stim [10];
  exp_t       expv [10];

  motor_mix_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .throttle_offset(throttle_offset), .pitch_offset(pitch_offset),
    .roll_offset(roll_offset), .yaw_offset(yaw_offset),
    .in_valid(in_valid), .in_ready(in_ready), .arm(arm),
    .motor0(motor0), .motor1(motor1), .motor2(motor2), .motor3(motor3),
    .out_valid(out_valid), .out_ready(out_ready),
    .sat_flag(sat_flag), .arm_state(arm_state)
  );

  // m0 subtracts pitch, m1 roll, m2 yaw, m3 all three.
  motor_mix_pipe #(.SIGN_MASK(12'hF11)) dut_x (
    .clk(clk), .rst_n(rst_n),
    .throttle_offset(throttle_offset), .pitch_offset(pitch_offset),
    .roll_offset(roll_offset), .yaw_offset(yaw_offset),
    .in_valid(in_valid), .in_ready(x_in_ready), .arm(arm),
    .motor0(xm0), .motor1(xm1), .motor2(xm2), .motor3(xm3),
    .out_valid(x_out_valid), .out_ready(out_ready),
    .sat_flag(x_sat), .arm_state(x_arm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] a, input logic [3:0] asat,
                              input logic [7:0] x0, input logic [7:0] x1,
                              input logic [7:0] x2, input logic [7:0] x3,
                              input logic [3:0] xsat);
    exp_t r;
    r.forced = 1'b0;
    r.a      = a;
    r.asat   = asat;
    r.x      = {x3, x2, x1, x0};
    r.xsat   = xsat;
    return r;
  endfunction

  function automatic exp_t forced_exp();
    exp_t r;
    r        = '0;
    r.forced = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] slew(input logic [7:0] last, input logic [7:0] tgt);
    int d;
    d = int'(tgt) - int'(last);
    if (d > 4) return 8'(int'(last) + 4);
    if (d < -4) return 8'(int'(last) - 4);
    return tgt;
  endfunction

  task automatic init_tables();
    stim[0] = 32'h05050505; expv[0] = mk(8'h46, 4'h0, 8'h3C, 8'h3C, 8'h3C, 8'h28, 4'h0);
    stim[1] = 32'h0A030714; expv[1] = mk(8'h5A, 4'h0, 8'h54, 8'h4C, 8'h32, 8'h1E, 4'h0);
    stim[2] = 32'hF6FDF9EC; expv[2] = mk(8'h0A, 4'h0, 8'h10, 8'h18, 8'h32, 8'h46, 4'h0);
    stim[3] = 32'h7F7F7F7F; expv[3] = mk(8'hFF, 4'hF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 4'hF);
    stim[4] = 32'h80808080; expv[4] = mk(8'h00, 4'hF, 8'h00, 8'h00, 8'h00, 8'hFF, 4'hF);
    stim[5] = 32'h7F4E0000; expv[5] = mk(8'hFF, 4'h0, 8'h63, 8'hFF, 8'hFF, 8'h63, 4'h0);
    stim[6] = 32'h7F4F0000; expv[6] = mk(8'hFF, 4'hF, 8'h62, 8'hFF, 8'hFF, 8'h62, 4'h6);
    stim[7] = 32'hCE000000; expv[7] = mk(8'h00, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    stim[8] = 32'hCD000000; expv[8] = mk(8'h00, 4'hF, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF);
    stim[9] = 32'h00000000; expv[9] = mk(8'h32, 4'h0, 8'h32, 8'h32, 8'h32, 8'h32, 4'h0);
  endtask

  // Present one input and push its expectation at the edge that accepts it.
  task automatic send(input logic [31:0] s, input exp_t e);
    int   n;
    logic acc;
    {throttle_offset, pitch_offset, roll_offset, yaw_offset} = s;
    in_valid = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) q.push_back(e);
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck at %0b, expected 1", in_ready);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d outputs pending, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic arm_for(input int cycles);
    arm = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Monitor: compare the head expectation whenever an output is presented.
  initial begin
    exp_t       e;
    logic [7:0] ea;
    logic [7:0] ex [4];
    logic [7:0] last_a;
    logic [7:0] last_x [4];
    last_a = 8'h00;
    for (int m = 0; m < 4; m++) last_x[m] = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_a = 8'h00;
        for (int m = 0; m < 4; m++) last_x[m] = 8'h00;
      end else if (out_valid) begin
        if (q.size() == 0) begin
          if (out_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: out_valid=%0b with nothing pending, expected 0",
                     out_valid);
          end
        end else begin
          e  = q[0];
          ea = e.a;
          for (int m = 0; m < 4; m++) ex[m] = e.x[m];
`ifdef MOTOR_MIX_SLEW_EN
          if (!e.forced) begin
            ea = slew(last_a, e.a);
            for (int m = 0; m < 4; m++) ex[m] = slew(last_x[m], e.x[m]);
          end
`endif
          check("motor0", 32'(motor0), 32'(ea));
          check("motor1", 32'(motor1), 32'(ea));
          check("motor2", 32'(motor2), 32'(ea));
          check("motor3", 32'(motor3), 32'(ea));
          check("sat_flag", 32'(sat_flag), 32'(e.asat));
          check("x_out_valid", 32'(x_out_valid), 32'd1);
          check("x_motor0", 32'(xm0), 32'(ex[0]));
          check("x_motor1", 32'(xm1), 32'(ex[1]));
          check("x_motor2", 32'(xm2), 32'(ex[2]));
          check("x_motor3", 32'(xm3), 32'(ex[3]));
          check("x_sat_flag", 32'(x_sat), 32'(e.xsat));
          if (out_ready) begin
            void'(q.pop_front());
            last_a = ea;
            for (int m = 0; m < 4; m++) last_x[m] = ex[m];
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    init_tables();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    arm = 1'b0;
    {throttle_offset, pitch_offset, roll_offset, yaw_offset} = 32'h0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_motor0", 32'(motor0), 32'd0);
    check("rst_motor3", 32'(motor3), 32'd0);
    check("rst_sat", 32'(sat_flag), 32'd0);
    check("rst_arm_state", 32'(arm_state), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_x_in_ready", 32'(x_in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Three arm cycles are not enough; outputs stay forced.
    arm_for(3);
    check("arm3_state", 32'(arm_state), 32'd1);
    arm = 1'b0;
    @(posedge clk);
    #1;
    check("disarm_state", 32'(arm_state), 32'd0);
    check("x_disarm_state", 32'(x_arm_state), 32'd0);
    send(stim[0], forced_exp());
    drain();

    // Four arm cycles arm the mixer; run the whole vector table back to back.
    arm_for(4);
    check("arm4_state", 32'(arm_state), 32'd2);
    for (int i = 0; i < 10; i++) send(stim[i], expv[i]);
    drain();

    // Output stall with fresh inputs queued behind it.
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 5; i++) send(stim[i], expv[i]);
      begin
        repeat (6) @(posedge clk);
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
      end
    join
    drain();

    // Disarm in the same cycle as the stage-2 load still forces OUT_MIN.
    send(stim[1], forced_exp());
    arm = 1'b0;
    drain();
    check("coincide_state", 32'(arm_state), 32'd0);

    // Reset in the middle of a stalled stream.
    arm_for(4);
    out_ready = 1'b0;
    send(stim[1], expv[1]);
    send(stim[2], expv[2]);
    #2;
    rst_n = 1'b0;
    arm = 1'b0;
    #1;
    q.delete();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_motor0", 32'(motor0), 32'd0);
    check("midrst_sat", 32'(sat_flag), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_arm_state", 32'(arm_state), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("postrst_no_output", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    arm_for(4);
    check("rearm_state", 32'(arm_state), 32'd2);
    send(stim[0], expv[0]);
    drain();

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_mix_pipe.md
MOTOR_MIX_PIPE -- requirements
Module: motor_mix_pipe

Interface
REQ-001 SHALL have parameter W, default 8: width of each signed offset and unsigned motor output.
REQ-002 SHALL have parameter BASE, default 50: hover base value added to every motor.
REQ-003 SHALL have parameter OUT_MIN, default 0: lower output clamp.
REQ-004 SHALL have parameter OUT_MAX, default 2^W-1: upper output clamp.
REQ-005 SHALL have parameter SIGN_MASK, 12 bits, default 0: bit 3*m+k set means motor m subtracts axis k (k=0 pitch, 1 roll, 2 yaw); 0 means all-add.
REQ-006 SHALL have parameter ARM_CYCLES, default 4: consecutive arm-high cycles required to arm.
REQ-007 SHALL have parameter SLEW_STEP, default 4: maximum per-transfer output change (used only under REQ-030).
REQ-008 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-009 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-010 SHALL have ports throttle_offset, pitch_offset, roll_offset, yaw_offset, input, W each: two's-complement offsets.
REQ-011 SHALL have ports in_valid (input, 1) and in_ready (output, 1): input handshake.
REQ-012 SHALL have port arm, input, 1: arm request level.
REQ-013 SHALL have ports motor0..motor3, output, W each: unsigned motor commands.
REQ-014 SHALL have ports out_valid (output, 1) and out_ready (input, 1): output handshake.
REQ-015 SHALL have port sat_flag, output, 4: bit m set when motor m was clamped.
REQ-016 SHALL have port arm_state, output, 2: 0 DISARMED, 1 ARMING, 2 ARMED.

Function
REQ-017 SHALL compute raw_m = BASE + throttle +/- pitch +/- roll +/- yaw per SIGN_MASK, sign-extended to W+3 bits with no intermediate overflow.
REQ-018 SHALL clamp raw_m to [OUT_MIN, OUT_MAX] and set sat_flag[m] when clamped.
REQ-019 SHALL be two pipeline stages: stage 1 registers raw sums, stage 2 registers clamped outputs; latency 2 cycles from accepted input to out_valid with no stalls.
REQ-020 SHALL accept input on in_valid && in_ready; SHALL advance the pipeline when out_valid == 0 or out_ready == 1; in_ready equals that advance condition.
REQ-021 SHALL hold motor0..3, sat_flag and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL propagate bubbles: stage valid bits track in_valid, so no output is produced without a corresponding accepted input.
REQ-023 SHALL run an arm FSM: DISARMED -> ARMING when arm=1; ARMING -> ARMED after ARM_CYCLES consecutive arm=1 cycles, counted from entry; any state -> DISARMED when arm=0.
REQ-024 SHALL force motor outputs produced at stage 2 to OUT_MIN with sat_flag=0 while arm_state != ARMED; the handshake continues normally.
REQ-025 SHALL give disarm priority: an arm=0 cycle affects the next stage-2 load even if that load coincides with the transition.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear both stage valid bits, out_valid=0, motor0..3=OUT_MIN, sat_flag=0, arm_state=DISARMED, arm counter=0.
REQ-027 SHALL discard in-flight data on reset mid-operation; in_ready=1 during and after reset.
REQ-028 SHALL leave the first post-reset output dependent only on inputs accepted after reset release.

Configuration
REQ-029 SHALL compile the slew limiter only when macro MOTOR_MIX_SLEW_EN is defined.
REQ-030 SHALL, with MOTOR_MIX_SLEW_EN defined, limit each motor's change per stage-2 load to +/-SLEW_STEP relative to the last loaded value; disarm forcing to OUT_MIN bypasses the limit; sat_flag reflects clamping only.
REQ-031 SHALL, without MOTOR_MIX_SLEW_EN, load the clamped value directly, with no slew registers.

Verification
REQ-032 Armed (arm high >= 4 cycles), all offsets 5, in_valid=1, out_ready=1 -> 2 cycles later motor0..3=8'h46, sat_flag=0.
REQ-033 Armed, all offsets 127, SIGN_MASK=0 -> motors=8'hFF, sat_flag=4'hF; all offsets -128 -> motors=8'h00, sat_flag=4'hF.
REQ-034 Armed, out_ready held low for 5 cycles with new inputs -> outputs frozen, in_ready=0 after the pipeline fills, no data lost after out_ready=1.
REQ-035 arm high 3 cycles then low, offsets 5 -> arm_state never reaches ARMED, motors=8'h00; arm high 4 cycles -> ARMED and motors=8'h46.
REQ-036 MOTOR_MIX_SLEW_EN, armed, step from offsets 0 (8'h32) to offsets 5 -> successive outputs 8'h36, 8'h3A, ... until 8'h46; rst_n pulsed mid-stream -> out_valid=0, motors=8'h00 immediately.
